// File: rtl/coef_rle_packer.sv
// Zero-run-length packer for lifting-stage coefficients, feeding a 4-entry token FIFO.
// Optional statistics outputs are built when RLE_STATS_EN is defined.
module coef_rle_packer #(
    parameter int QSHIFT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_coef,
    input  logic        in_is_h,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data
`ifdef RLE_STATS_EN
    ,
    output logic [15:0] tok_count,
    output logic [15:0] zero_count
`endif
);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t           state, nxt_state;
    logic [7:0]       run_cnt, nxt_cnt;
    logic [15:0]      mem [4];
    logic [1:0]       rd_ptr, wr_ptr;
    logic [2:0]       fill;
    logic [2:0][15:0] tok;
    logic [1:0]       n_tok;
    logic             push, pop, h_zero;
    logic [8:0]       mag, qmag;
    logic [7:0]       q;

    assign pop       = out_valid & out_ready;
    assign push      = in_valid & in_ready;
    assign out_valid = (fill != 3'd0);
    assign out_data  = out_valid ? mem[rd_ptr] : 16'h0000;
    // A coefficient can emit up to 3 tokens, so accept only with 3 slots free after this pop.
    assign in_ready  = ((fill - {2'b00, pop}) <= 3'd1);

    // Magnitude kept in 9 bits so that -128 quantizes as +128 >> QSHIFT.
    always_comb begin
        mag  = in_coef[7] ? (9'd256 - {1'b0, in_coef}) : {1'b0, in_coef};
        qmag = mag >> QSHIFT;
        q    = in_coef[7] ? (8'd0 - qmag[7:0]) : qmag[7:0];
    end

    assign h_zero = in_is_h && (q == 8'd0);

    always_comb begin
        tok       = '0;
        n_tok     = 2'd0;
        nxt_cnt   = run_cnt;
        nxt_state = state;
        if (h_zero) begin
            if (state == S_RUN && run_cnt == 8'd254) begin
                tok[0]  = 16'h80FF;
                n_tok   = 2'd1;
                nxt_cnt = 8'd0;
            end else begin
                nxt_cnt = run_cnt + 8'd1;
            end
        end else begin
            if (state == S_RUN) begin
                tok[n_tok] = {2'b10, 6'd0, run_cnt};
                n_tok      = n_tok + 2'd1;
            end
            tok[n_tok] = in_is_h ? {2'b01, 6'd0, q} : {2'b00, 6'd0, in_coef};
            n_tok      = n_tok + 2'd1;
            nxt_cnt    = 8'd0;
        end
        if (in_last) begin
            if (nxt_cnt != 8'd0) begin
                tok[n_tok] = {2'b10, 6'd0, nxt_cnt};
                n_tok      = n_tok + 2'd1;
            end
            tok[n_tok] = 16'hC000;
            n_tok      = n_tok + 2'd1;
            nxt_cnt    = 8'd0;
        end
        nxt_state = (nxt_cnt != 8'd0) ? S_RUN : S_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            run_cnt <= 8'd0;
            rd_ptr  <= 2'd0;
            wr_ptr  <= 2'd0;
            fill    <= 3'd0;
            for (int i = 0; i < 4; i++) mem[i] <= 16'h0000;
        end else begin
            if (push) begin
                for (int i = 0; i < 3; i++)
                    if (2'(i) < n_tok) mem[wr_ptr + 2'(i)] <= tok[i];
                wr_ptr  <= wr_ptr + n_tok;
                state   <= nxt_state;
                run_cnt <= nxt_cnt;
            end
            if (pop) rd_ptr <= rd_ptr + 2'd1;
            fill <= fill + (push ? {1'b0, n_tok} : 3'd0) - {2'b00, pop};
        end
    end

`ifdef RLE_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tok_count  <= 16'd0;
            zero_count <= 16'd0;
        end else begin
            if (pop && tok_count != 16'hFFFF) tok_count <= tok_count + 16'd1;
            if (push && h_zero && zero_count != 16'hFFFF) zero_count <= zero_count + 16'd1;
        end
    end
`endif

endmodule
